// File: rtl/input_debouncer_pkg.sv
// Shared types and default constants for the input debouncer slice.
package debounce_pkg;

  localparam int DEFAULT_SYNC_STAGES     = 2;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

  // Debounce FSM states: two settled levels and two pending-change states.
  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } deb_state_t;

endpackage

// File: rtl/input_debouncer_if.sv
// Signal bundle between the debouncer and its environment.
// There is no valid/ready handshake here: raw_in is a free-running level that
// may change at any time, and level_out/rise_pulse/fall_pulse are registered
// status outputs valid on every cycle (pulses last exactly one clock).
// state exposes the debounce FSM for observation only.
interface input_debouncer_if;
  import debounce_pkg::*;

  logic       raw_in;
  logic       level_out;
  logic       rise_pulse;
  logic       fall_pulse;
  deb_state_t state;

  modport master (
    output raw_in,
    input  level_out,
    input  rise_pulse,
    input  fall_pulse,
    input  state
  );

  modport slave (
    input  raw_in,
    output level_out,
    output rise_pulse,
    output fall_pulse,
    output state
  );

endinterface

// File: rtl/input_debouncer_sync_chain.sv
// Multi-flop synchronizer that brings the asynchronous raw input into the
// clk_signal domain. All stages clear to 0 on reset.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk_signal,
  input  logic reset_signal,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] flops;

  // Shift the input through the chain; the oldest stage is the synchronized sample.
  always_ff @(posedge clk_signal or posedge reset_signal) begin
    if (reset_signal) begin
      flops <= '0;
    end else begin
      flops <= {flops[STAGES-2:0], d};
    end
  end

  assign q = flops[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Debouncer for a bouncing push-button/switch input. The synchronized sample
// must differ from the current level for DEBOUNCE_CYCLES+1 consecutive edges
// (the first sample enters the wait state, DEBOUNCE_CYCLES more confirm it)
// before level_out changes; each accepted change emits a one-cycle pulse.
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input logic               clk_signal,
  input logic               reset_signal,
  input_debouncer_if.slave  io
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] COUNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] COUNT_ONE = CW'(1);

  logic          s;
  deb_state_t    state;
  logic [CW-1:0] count;
  logic          level_r;
  logic          rise_r;
  logic          fall_r;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_signal   (clk_signal),
    .reset_signal (reset_signal),
    .d            (io.raw_in),
    .q            (s)
  );

  // Debounce FSM with its confirmation counter and registered level/pulse
  // outputs. Pulses default low so they last exactly one cycle; the count is
  // cleared on every exit from a wait state so it never exceeds COUNT_MAX.
  always_ff @(posedge clk_signal or posedge reset_signal) begin
    if (reset_signal) begin
      state   <= STABLE_LOW;
      count   <= '0;
      level_r <= 1'b0;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
    end else begin
      rise_r <= 1'b0;
      fall_r <= 1'b0;
      case (state)
        STABLE_LOW: begin
          if (s) begin
            state <= WAIT_HIGH;
            count <= COUNT_ONE;
          end
        end
        WAIT_HIGH: begin
          if (!s) begin
            state <= STABLE_LOW;
            count <= '0;
          end else if (count == COUNT_MAX) begin
            state   <= STABLE_HIGH;
            level_r <= 1'b1;
            rise_r  <= 1'b1;
            count   <= '0;
          end else begin
            count <= count + COUNT_ONE;
          end
        end
        STABLE_HIGH: begin
          if (!s) begin
            state <= WAIT_LOW;
            count <= COUNT_ONE;
          end
        end
        WAIT_LOW: begin
          if (s) begin
            state <= STABLE_HIGH;
            count <= '0;
          end else if (count == COUNT_MAX) begin
            state   <= STABLE_LOW;
            level_r <= 1'b0;
            fall_r  <= 1'b1;
            count   <= '0;
          end else begin
            count <= count + COUNT_ONE;
          end
        end
        default: begin
          state   <= STABLE_LOW;
          count   <= '0;
          level_r <= 1'b0;
        end
      endcase
    end
  end

  assign io.level_out  = level_r;
  assign io.rise_pulse = rise_r;
  assign io.fall_pulse = fall_r;
  assign io.state      = state;

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer: directed scenarios plus random
// bouncing, checked cycle by cycle against a run-length reference model.
module tb_input_debouncer;
  import debounce_pkg::*;

  localparam int SYNC = 2;
  localparam int DEB  = 4;

  // ---------------- clock / reset ----------------
  logic clk_signal = 1'b0;
  logic reset_signal = 1'b1;
  always #5 clk_signal = ~clk_signal;

  input_debouncer_if dif ();

  input_debouncer #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk_signal   (clk_signal),
    .reset_signal (reset_signal),
    .io           (dif)
  );

  // Downstream D flip-flop fed by level_out.
  logic q_output;
  always @(posedge clk_signal or posedge reset_signal) begin
    if (reset_signal) q_output <= 1'b0;
    else              q_output <= dif.level_out;
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  int rise_cnt = 0;
  int fall_cnt = 0;
  logic [2:0] exp_q[$];

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The debounced level flips once the synchronized input (raw delayed by SYNC
  // edges) has disagreed with it for DEB+1 consecutive edges.
  logic hist_q[$];
  logic level_m = 1'b0;
  int   run_m = 0;

  always @(posedge clk_signal) begin
    logic s_m;
    logic r_m;
    logic f_m;
    if (reset_signal) begin
      hist_q.delete();
      for (int i = 0; i <= SYNC; i++) hist_q.push_back(1'b0);
      level_m = 1'b0;
      run_m   = 0;
    end else begin
      hist_q.push_front(dif.raw_in);
      s_m = hist_q[SYNC];
      void'(hist_q.pop_back());
      r_m = 1'b0;
      f_m = 1'b0;
      if (s_m == level_m) begin
        run_m = 0;
      end else begin
        run_m++;
        if (run_m == DEB + 1) begin
          level_m = s_m;
          run_m   = 0;
          r_m     = s_m;
          f_m     = !s_m;
        end
      end
      exp_q.push_back({level_m, r_m, f_m});
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk_signal) begin
    logic [2:0] act;
    act = {dif.level_out, dif.rise_pulse, dif.fall_pulse};
    if (reset_signal) begin
      check("reset_outputs", act, 3'b000);
    end else if (exp_q.size() == 0) begin
      check("scoreboard_empty", 3'b001, 3'b000);
    end else begin
      check("cycle_outputs", act, exp_q.pop_front());
      check("pulse_exclusive", {2'b00, dif.rise_pulse & dif.fall_pulse}, 3'b000);
      if (dif.rise_pulse) rise_cnt++;
      if (dif.fall_pulse) fall_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk_signal);
    #1;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int r0;
    int f0;
    dif.raw_in   = 1'b0;
    reset_signal = 1'b1;
    tick(3);
    check("reset_state", {1'b0, dif.state}, {1'b0, STABLE_LOW});
    reset_signal = 1'b0;
    tick(5);

    // Clean rise: level_out and rise_pulse at edge 7.
    r0 = rise_cnt;
    dif.raw_in = 1'b1;
    tick(6);
    check("rise_e6_level", {2'b00, dif.level_out}, 3'b000);
    tick(1);
    check("rise_e7_level", {2'b00, dif.level_out}, 3'b001);
    check("rise_e7_pulse", {2'b00, dif.rise_pulse}, 3'b001);
    tick(1);
    check("rise_e8_pulse", {2'b00, dif.rise_pulse}, 3'b000);
    check("rise_count", 3'(rise_cnt - r0), 3'd1);

    // Short glitch low from STABLE_HIGH.
    tick(4);
    f0 = fall_cnt;
    dif.raw_in = 1'b0;
    tick(3);
    dif.raw_in = 1'b1;
    tick(12);
    check("glitch_level", {2'b00, dif.level_out}, 3'b001);
    check("glitch_no_fall", 3'(fall_cnt - f0), 3'd0);

    // Clean fall, with the downstream flop one edge behind.
    f0 = fall_cnt;
    dif.raw_in = 1'b0;
    tick(6);
    check("fall_e6_level", {2'b00, dif.level_out}, 3'b001);
    tick(1);
    check("fall_e7_level", {2'b00, dif.level_out}, 3'b000);
    check("fall_e7_pulse", {2'b00, dif.fall_pulse}, 3'b001);
    check("fall_e7_q", {2'b00, q_output}, 3'b001);
    tick(1);
    check("fall_e8_q", {2'b00, q_output}, 3'b000);
    check("fall_e8_pulse", {2'b00, dif.fall_pulse}, 3'b000);
    check("fall_count", 3'(fall_cnt - f0), 3'd1);

    // Bounce 1,0,1,0... for 8 cycles, then hold high.
    tick(4);
    r0 = rise_cnt;
    for (int i = 0; i < 8; i++) begin
      dif.raw_in = (i % 2 == 0);
      tick(1);
    end
    dif.raw_in = 1'b1;
    tick(6);
    check("bounce_no_early_rise", 3'(rise_cnt - r0), 3'd0);
    tick(1);
    check("bounce_e7_pulse", {2'b00, dif.rise_pulse}, 3'b001);
    tick(5);
    check("bounce_single_rise", 3'(rise_cnt - r0), 3'd1);

    // Reset between edges with raw_in high: outputs clear at once.
    tick(2);
    #2;
    reset_signal = 1'b1;
    #1;
    check("async_reset_out", {dif.level_out, dif.rise_pulse, dif.fall_pulse}, 3'b000);
    check("async_reset_state", {1'b0, dif.state}, {1'b0, STABLE_LOW});
    tick(2);
    reset_signal = 1'b0;
    r0 = rise_cnt;
    tick(6);
    check("post_reset_e6_level", {2'b00, dif.level_out}, 3'b000);
    tick(1);
    check("post_reset_e7_pulse", {2'b00, dif.rise_pulse}, 3'b001);
    tick(2);
    check("post_reset_rise_count", 3'(rise_cnt - r0), 3'd1);

    // Reset in the middle of a debounce window.
    dif.raw_in = 1'b0;
    tick(10);
    r0 = rise_cnt;
    dif.raw_in = 1'b1;
    tick(4);
    reset_signal = 1'b1;
    #1;
    check("mid_reset_level", {2'b00, dif.level_out}, 3'b000);
    check("mid_reset_no_rise", 3'(rise_cnt - r0), 3'd0);
    tick(1);
    reset_signal = 1'b0;
    tick(6);
    check("mid_reset_e6_level", {2'b00, dif.level_out}, 3'b000);
    check("mid_reset_e6_count", 3'(rise_cnt - r0), 3'd0);
    tick(1);
    check("mid_reset_e7_pulse", {2'b00, dif.rise_pulse}, 3'b001);
    tick(1);
    check("mid_reset_rise_count", 3'(rise_cnt - r0), 3'd1);

    // Random bouncing input with assorted hold lengths.
    for (int seg = 0; seg < 60; seg++) begin
      dif.raw_in = 1'($urandom_range(0, 1));
      tick($urandom_range(1, 9));
    end
    tick(20);
    check("queue_drained", 3'(exp_q.size()), 3'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #100000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on raw_in (legal range 2..4).
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, number of consecutive stable synchronized samples required to accept a change (legal range >= 1).
REQ-003 The block SHALL have port clk_signal, input, 1 bit, single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_signal, input, 1 bit, asynchronous active-high reset.
REQ-005 The block SHALL have port raw_in, input, 1 bit, asynchronous bouncing input (push-button/switch).
REQ-006 The block SHALL have port level_out, output, 1 bit, registered debounced level; drives the d_input of the downstream D flip-flop stage.
REQ-007 The block SHALL have port rise_pulse, output, 1 bit, registered one-cycle pulse on an accepted 0->1 change of level_out.
REQ-008 The block SHALL have port fall_pulse, output, 1 bit, registered one-cycle pulse on an accepted 1->0 change of level_out.

Function
REQ-009 raw_in SHALL pass through a SYNC_STAGES-deep flop chain; the last stage output is the sample s.
REQ-010 The FSM SHALL have states STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW.
REQ-011 STABLE_LOW with s=1 SHALL go to WAIT_HIGH and load count=1; with s=0 it SHALL stay.
REQ-012 WAIT_HIGH with s=0 SHALL abort to STABLE_LOW, clear count, and emit no pulse.
REQ-013 WAIT_HIGH with s=1 and count<DEBOUNCE_CYCLES SHALL increment count.
REQ-014 WAIT_HIGH with s=1 and count=DEBOUNCE_CYCLES SHALL go to STABLE_HIGH, set level_out=1, assert rise_pulse for exactly that cycle, and clear count.
REQ-015 STABLE_HIGH, WAIT_LOW SHALL mirror REQ-011..014 with inverted polarity, producing level_out=0 and fall_pulse.
REQ-016 Latency: a clean raw_in change present before edge 1 SHALL appear on level_out after edge SYNC_STAGES+DEBOUNCE_CYCLES+1 (7 with defaults).
REQ-017 rise_pulse and fall_pulse SHALL never be asserted together and SHALL deassert on the following edge.
REQ-018 Counter width SHALL be $clog2(DEBOUNCE_CYCLES+1) bits and SHALL never wrap; the count is bounded by REQ-014.
REQ-019 Any glitch on s shorter than the debounce window SHALL leave level_out unchanged.

Reset
REQ-020 While reset_signal=1, independent of clk_signal, all sync flops, count, level_out, rise_pulse and fall_pulse SHALL be 0, and the state SHALL be STABLE_LOW.
REQ-021 Reset asserted mid-debounce SHALL discard the partial count; no pulse SHALL be emitted for it.
REQ-022 After reset release with raw_in held 1, the block SHALL debounce normally and emit one rise_pulse per REQ-016 latency.

Structure
REQ-023 Package debounce_pkg SHALL hold the FSM state enum typedef and the default SYNC_STAGES/DEBOUNCE_CYCLES constants.
REQ-024 The synchronizer SHALL be a sub-module sync_chain (parameter STAGES, async active-high reset to 0); FSM, counter and output registers SHALL live in input_debouncer.

Verification
REQ-025 Reset: assert reset_signal between clock edges with raw_in=1 -> level_out, rise_pulse, fall_pulse go 0 immediately.
REQ-026 Clean rise (defaults): raw_in 0->1 held -> level_out=1 after edge 7, rise_pulse high for exactly one cycle at edge 7.
REQ-027 Bounce: raw_in toggles 1,0,1,0 each cycle for 8 cycles, then held 1 -> exactly one rise_pulse, 7 edges after the final hold begins.
REQ-028 Short glitch: from STABLE_HIGH, raw_in=0 for 3 cycles then back to 1 -> level_out stays 1, no fall_pulse.
REQ-029 Mid-debounce reset: raw_in 0->1, reset pulsed at edge 5, raw_in kept 1 -> no pulse before reset; single rise_pulse 7 edges after release.
REQ-030 Clean fall: from STABLE_HIGH, raw_in 1->0 held -> level_out=0 after edge 7, single fall_pulse, downstream DFF q_output follows one edge later.
